// File: rtl/even_parity_checker_rx_if.sv
// Bundle for the even-parity serial receiver: serial bit strobe in, word and status out.
// master = bit source / word consumer, slave = receiver.
interface even_parity_checker_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              din;
  logic              din_valid;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output din, din_valid,
    input  data_out, out_valid, parity_err, frame_err, busy, err_count
  );

  modport slave (
    input  din, din_valid,
    output data_out, out_valid, parity_err, frame_err, busy, err_count
  );
endinterface

// File: rtl/even_parity_checker_rx.sv
// Even-parity serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Optional saturating parity-error counter enabled by defining PARITY_ERR_CNT_EN.
//
//  state  | meaning
//  IDLE   | waiting for a start bit (din=0 strobe); din=1 strobes ignored
//  DATA   | collecting data bits into shift_q[cnt_q], accumulating parity
//  PARITY | folding the received parity bit into the running parity
//  STOP   | sampling stop bit; publishes word and status on this strobe
module even_parity_checker_rx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  even_parity_checker_rx_if.slave rx
);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              run_par_q, run_par_d;
  logic              par_calc_q, par_calc_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              busy;
  logic              stop_hit;

  assign stop_hit = (state_q == STOP) && rx.din_valid;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (rx.din_valid) begin
      unique case (state_q)
        IDLE:    if (!rx.din) state_d = DATA;
        DATA:    if (cnt_q == LAST_IDX) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  // datapath next values
  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    run_par_d    = run_par_q;
    par_calc_d   = par_calc_q;
    data_out_d   = data_out_q;
    out_valid_d  = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    if (rx.din_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!rx.din) begin
            cnt_d     = '0;
            run_par_d = 1'b0;
          end
        end
        DATA: begin
          shift_d[cnt_q] = rx.din;
          run_par_d      = run_par_q ^ rx.din;
          cnt_d          = cnt_q + 1'b1;
        end
        PARITY: begin
          par_calc_d = run_par_q ^ rx.din;
        end
        STOP: begin
          data_out_d   = shift_q;
          parity_err_d = par_calc_q;
          frame_err_d  = ~rx.din;
          out_valid_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      run_par_q    <= 1'b0;
      par_calc_q   <= 1'b0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      run_par_q    <= run_par_d;
      par_calc_q   <= par_calc_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // updates on the same edge as out_valid so the count is current with the pulse
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (stop_hit && par_calc_q && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign rx.err_count = err_cnt_q;
`else
  logic unused_stop_hit;
  assign unused_stop_hit = stop_hit;
  assign rx.err_count    = {CNT_W{1'b0}};
`endif

  assign rx.data_out   = data_out_q;
  assign rx.out_valid  = out_valid_q;
  assign rx.parity_err = parity_err_q;
  assign rx.frame_err  = frame_err_q;
  assign rx.busy       = busy;
endmodule

// File: tb/tb_even_parity_checker_rx.sv
// Directed bench for even_parity_checker_rx with a frame-level expectation model.
module tb_even_parity_checker_rx;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  even_parity_checker_rx_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  even_parity_checker_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // driver-side intent, set together with each strobe
  logic              drv_start = 1'b0;
  logic              drv_stop  = 1'b0;
  logic [DATA_W-1:0] drv_data  = '0;
  logic              drv_pe    = 1'b0;
  logic              drv_fe    = 1'b0;

  // frame-level model
  logic              in_frame  = 1'b0;
  logic              pulse_due = 1'b0;
  logic [DATA_W-1:0] exp_data  = '0;
  logic              exp_pe    = 1'b0;
  logic              exp_fe    = 1'b0;
  int                exp_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      in_frame = 1'b0; pulse_due = 1'b0;
      exp_data = '0; exp_pe = 1'b0; exp_fe = 1'b0; exp_cnt = 0;
    end else begin
      pulse_due = 1'b0;
      if (bus.din_valid) begin
        if (!in_frame && drv_start) in_frame = 1'b1;
        else if (in_frame && drv_stop) begin
          in_frame  = 1'b0;
          pulse_due = 1'b1;
          exp_data  = drv_data;
          exp_pe    = drv_pe;
          exp_fe    = drv_fe;
`ifdef PARITY_ERR_CNT_EN
          if (drv_pe && exp_cnt < CNT_MAX) exp_cnt++;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid",  {31'd0, bus.out_valid},  {31'd0, pulse_due});
    chk("busy",       {31'd0, bus.busy},       {31'd0, in_frame});
    chk("data_out",   32'(bus.data_out),       32'(exp_data));
    chk("parity_err", {31'd0, bus.parity_err}, {31'd0, exp_pe});
    chk("frame_err",  {31'd0, bus.frame_err},  {31'd0, exp_fe});
    chk("err_count",  32'(bus.err_count),      32'(exp_cnt));
  end

  // called at a negedge; returns at the following negedge with din_valid low
  task automatic strobe(input logic b, input logic is_start, input logic is_stop);
    bus.din = b; bus.din_valid = 1'b1;
    drv_start = is_start; drv_stop = is_stop;
    @(negedge clk);
    bus.din_valid = 1'b0; drv_start = 1'b0; drv_stop = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    int n;
    n = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int i = 0; i < n; i++) begin
      bus.din = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p,
                            input logic stop, input int max_gap);
    int ones;
    ones = 0;
    for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
    drv_data = d;
    drv_pe   = ((ones + int'(p)) % 2) != 0;
    drv_fe   = ~stop;
    gap(max_gap); strobe(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      gap(max_gap); strobe(d[i], 1'b0, 1'b0);
    end
    gap(max_gap); strobe(p, 1'b0, 1'b0);
    gap(max_gap); strobe(stop, 1'b0, 1'b1);
  endtask

  task automatic pulse_rst;
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.din = 1'b1; bus.din_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset data_out", 32'(bus.data_out), 32'h0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);

    // 1: clean frame
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    chk("t1 pulse", {31'd0, bus.out_valid}, 32'd1);
    chk("t1 data", 32'(bus.data_out), 32'hA5);
    chk("t1 perr", {31'd0, bus.parity_err}, 32'd0);
    @(negedge clk);
    chk("t1 pulse width", {31'd0, bus.out_valid}, 32'd0);
    chk("t1 busy after", {31'd0, bus.busy}, 32'd0);

    // 2: bad parity
    send_frame(8'h07, 1'b0, 1'b1, 0);
    chk("t2 data", 32'(bus.data_out), 32'h07);
    chk("t2 perr", {31'd0, bus.parity_err}, 32'd1);
`ifdef PARITY_ERR_CNT_EN
    chk("t2 err_count", 32'(bus.err_count), 32'd1);
`else
    chk("t2 err_count", 32'(bus.err_count), 32'd0);
`endif

    // 3: framing error, back-to-back with a new frame
    send_frame(8'h00, 1'b0, 1'b0, 0);
    chk("t3 ferr", {31'd0, bus.frame_err}, 32'd1);
    chk("t3 perr", {31'd0, bus.parity_err}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    chk("t3b ferr", {31'd0, bus.frame_err}, 32'd0);

    // 4: idle ones ignored, then gapped frame
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 1'b0);
    chk("t4 idle busy", {31'd0, bus.busy}, 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, 3);
    chk("t4 data", 32'(bus.data_out), 32'h3C);
    chk("t4 pulse", {31'd0, bus.out_valid}, 32'd1);

    // 5: reset mid-frame
    strobe(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'(i), 1'b0, 1'b0);
    chk("t5 busy mid", {31'd0, bus.busy}, 32'd1);
    pulse_rst();
    chk("t5 busy after rst", {31'd0, bus.busy}, 32'd0);
    chk("t5 data after rst", 32'(bus.data_out), 32'h0);
    send_frame(8'h81, 1'b0, 1'b1, 1);
    chk("t5 data", 32'(bus.data_out), 32'h81);
    chk("t5 perr", {31'd0, bus.parity_err}, 32'd0);

    // 6: saturating error count
    pulse_rst();
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h01, 1'b0, 1'b1, 0);
`ifdef PARITY_ERR_CNT_EN
      chk("t6 err_count", 32'(bus.err_count), (k < 3) ? 32'(k + 1) : 32'd3);
`else
      chk("t6 err_count", 32'(bus.err_count), 32'd0);
`endif
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
